// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter that sequences requests onto a shared 8-bit ALU
// and returns the captured RESULT/ZERO over a per-requester valid/ready response.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req0_valid,
    input  logic       i_req1_valid,
    output logic       o_req0_ready,
    output logic       o_req1_ready,
    input  logic [7:0] i_req0_data1,
    input  logic [7:0] i_req1_data1,
    input  logic [7:0] i_req0_data2,
    input  logic [7:0] i_req1_data2,
    input  logic [2:0] i_req0_select,
    input  logic [2:0] i_req1_select,
    output logic [7:0] o_alu_data1,
    output logic [7:0] o_alu_data2,
    output logic [2:0] o_alu_select,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_zero,
    output logic       o_rsp0_valid,
    output logic       o_rsp1_valid,
    input  logic       i_rsp0_ready,
    input  logic       i_rsp1_ready,
    output logic [7:0] o_rsp_result,
    output logic       o_rsp_zero,
    output logic       o_rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [1:0] CNT_INIT = 2'(SETTLE - 1);
    state_t     r_state, w_state_nxt;
    logic       r_last, r_owner;
    logic [1:0] r_cnt;
    logic       w_gnt, w_accept, w_rsp_ready;
    logic [7:0] w_data1, w_data2;
    logic [2:0] w_select;
    // On a tie the requester that did not win last time gets the grant.
    assign w_gnt        = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
    assign o_req0_ready = (r_state == IDLE) & ~w_gnt & i_req0_valid & i_reset_n;
    assign o_req1_ready = (r_state == IDLE) &  w_gnt & i_req1_valid & i_reset_n;
    assign w_accept     = o_req0_ready | o_req1_ready;
    assign w_data1      = w_gnt ? i_req1_data1  : i_req0_data1;
    assign w_data2      = w_gnt ? i_req1_data2  : i_req0_data2;
    assign w_select     = w_gnt ? i_req1_select : i_req0_select;
    assign w_rsp_ready  = r_owner ? i_rsp1_ready : i_rsp0_ready;
    assign o_rsp0_valid = (r_state == RESP) & ~r_owner;
    assign o_rsp1_valid = (r_state == RESP) &  r_owner;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_select[2] ? RESP : EXEC;
            EXEC:    if (r_cnt == 2'd0) w_state_nxt = RESP;
            RESP:    if (w_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= 2'd0;
            o_alu_data1  <= 8'h00;
            o_alu_data2  <= 8'h00;
            o_alu_select <= 3'b000;
            o_rsp_result <= 8'h00;
            o_rsp_zero   <= 1'b0;
            o_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_gnt;
                r_last  <= w_gnt;
                // Illegal functions never reach the ALU; they answer straight away with ERR.
                if (w_select[2]) begin
                    o_rsp_result <= 8'h00;
                    o_rsp_zero   <= 1'b0;
                    o_rsp_err    <= 1'b1;
                end else begin
                    o_alu_data1  <= w_data1;
                    o_alu_data2  <= w_data2;
                    o_alu_select <= w_select;
                    r_cnt        <= CNT_INIT;
                end
            end
            if (r_state == EXEC) begin
                if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end else begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_zero   <= i_alu_zero;
                    o_rsp_err    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level
// model of grant order, response timing and ALU results.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int SETTLE = 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [1:0] v, rr;
    logic [7:0] d1 [2];
    logic [7:0] d2 [2];
    logic [2:0] sel [2];
    logic       r0, r1, rv0, rv1, alu_zero, rsp_zero, rsp_err;
    logic [7:0] alu_d1, alu_d2, alu_res, rsp_res;
    logic [2:0] alu_sel;

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return a;
            3'd1:    return 8'(a + b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res  = alu_f(alu_sel, alu_d1, alu_d2);
    assign alu_zero = (alu_res == 8'h00);

    alu_arbiter #(.SETTLE(SETTLE)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0_valid(v[0]), .i_req1_valid(v[1]),
        .o_req0_ready(r0), .o_req1_ready(r1),
        .i_req0_data1(d1[0]), .i_req1_data1(d1[1]),
        .i_req0_data2(d2[0]), .i_req1_data2(d2[1]),
        .i_req0_select(sel[0]), .i_req1_select(sel[1]),
        .o_alu_data1(alu_d1), .o_alu_data2(alu_d2), .o_alu_select(alu_sel),
        .i_alu_result(alu_res), .i_alu_zero(alu_zero),
        .o_rsp0_valid(rv0), .o_rsp1_valid(rv1),
        .i_rsp0_ready(rr[0]), .i_rsp1_ready(rr[1]),
        .o_rsp_result(rsp_res), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err)
    );

    // Second instance with the slowest settle time, both requesters always pending.
    logic       v4 = 1'b0;
    logic       s4_r0, s4_r1, s4_rv0, s4_rv1, s4_zero, s4_rz, s4_re;
    logic [7:0] s4_d1, s4_d2, s4_res, s4_rres;
    logic [2:0] s4_sel;
    assign s4_res  = alu_f(s4_sel, s4_d1, s4_d2);
    assign s4_zero = (s4_res == 8'h00);
    alu_arbiter #(.SETTLE(4)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0_valid(v4), .i_req1_valid(v4),
        .o_req0_ready(s4_r0), .o_req1_ready(s4_r1),
        .i_req0_data1(8'h11), .i_req1_data1(8'h22),
        .i_req0_data2(8'h01), .i_req1_data2(8'h02),
        .i_req0_select(3'b001), .i_req1_select(3'b011),
        .o_alu_data1(s4_d1), .o_alu_data2(s4_d2), .o_alu_select(s4_sel),
        .i_alu_result(s4_res), .i_alu_zero(s4_zero),
        .o_rsp0_valid(s4_rv0), .o_rsp1_valid(s4_rv1),
        .i_rsp0_ready(1'b1), .i_rsp1_ready(1'b1),
        .o_rsp_result(s4_rres), .o_rsp_zero(s4_rz), .o_rsp_err(s4_re)
    );
    int q4_id [$];
    int q4_cyc [$];
    always @(negedge clk) if (s4_r0 | s4_r1) begin
        q4_id.push_back(int'(s4_r1));
        q4_cyc.push_back(cyc_n);
    end

    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a request is outstanding from accept until its response handshake;
    // m_wait counts edges until the response becomes visible.
    bit         m_busy, m_owner, m_last, m_zero, m_err, m_done;
    int         m_wait, m_acc;
    logic [7:0] m_res, m_a1, m_a2;
    logic [2:0] m_as;

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_wait = 0; m_acc = -1; m_done = 0;
        m_res = 8'h00; m_zero = 0; m_err = 0; m_a1 = 8'h00; m_a2 = 8'h00; m_as = 3'b000;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready0"}, r0, 0);
        chk({tag, "_ready1"}, r1, 0);
        chk({tag, "_rspv0"}, rv0, 0);
        chk({tag, "_rspv1"}, rv1, 0);
        chk({tag, "_alu_d1"}, alu_d1, 0);
        chk({tag, "_alu_d2"}, alu_d2, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_rsp_res"}, rsp_res, 0);
        chk({tag, "_rsp_zero"}, rsp_zero, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    task automatic cyc();
        bit g, er0, er1, id;
        @(negedge clk);
        g   = (v[0] & v[1]) ? !m_last : v[1];
        er0 = !m_busy && v[0] && !g;
        er1 = !m_busy && v[1] && g;
        chk("ready0", r0, er0);
        chk("ready1", r1, er1);
        chk("rspv0", rv0, m_busy && m_wait == 0 && !m_owner);
        chk("rspv1", rv1, m_busy && m_wait == 0 && m_owner);
        chk("rsp_res", rsp_res, m_res);
        chk("rsp_zero", rsp_zero, m_zero);
        chk("rsp_err", rsp_err, m_err);
        chk("alu_d1", alu_d1, m_a1);
        chk("alu_d2", alu_d2, m_a2);
        chk("alu_sel", alu_sel, m_as);
        m_acc = -1; m_done = 0;
        if (m_busy) begin
            if (m_wait == 0) begin
                if (rr[m_owner]) begin m_busy = 0; m_done = 1; end
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_res = alu_f(m_as, m_a1, m_a2); m_zero = (m_res == 0); m_err = 0;
                end
            end
        end else if (er0 | er1) begin
            id = er1;
            m_busy = 1; m_owner = id; m_last = id; m_acc = int'(id);
            if (sel[id][2]) begin
                m_wait = 0; m_res = 8'h00; m_zero = 0; m_err = 1;
            end else begin
                m_wait = SETTLE; m_a1 = d1[id]; m_a2 = d2[id]; m_as = sel[id];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_req(input int n, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] s, output int lat);
        bit acc = 0, done = 0;
        lat = -1;
        d1[n] = a; d2[n] = b; sel[n] = s; v[n] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (m_acc == n) begin acc = 1; break; end
        end
        v[n] = 1'b0;
        chk("tmo_accept", acc, 1);
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (m_done) begin done = 1; lat = j + 1; break; end
        end
        chk("tmo_rsp", done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && m_busy; i++) cyc();
        chk("tmo_drain", m_busy, 0);
    endtask

    initial begin
        int lat, hd, ac, first;
        int ids [$];
        int cycs [$];
        v = 2'b00; rr = 2'b11;
        for (int n = 0; n < 2; n++) begin d1[n] = 0; d2[n] = 0; sel[n] = 0; end
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;

        run_req(0, 8'h05, 8'h03, 3'b001, lat);
        chk("add_res", rsp_res, 8'h08);
        chk("add_zero", rsp_zero, 0);
        chk("add_err", rsp_err, 0);
        chk("add_lat", lat, 2);

        run_req(1, 8'hF0, 8'h0F, 3'b010, lat);
        chk("and_res", rsp_res, 8'h00);
        chk("and_zero", rsp_zero, 1);
        chk("and_sel", alu_sel, 3'b010);
        run_req(1, 8'hFF, 8'h01, 3'b001, lat);
        chk("wrap_res", rsp_res, 8'h00);
        chk("wrap_zero", rsp_zero, 1);
        chk("wrap_sel", alu_sel, 3'b001);

        rst_n = 1'b0; m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        d1[0] = 8'h12; d2[0] = 8'h34; sel[0] = 3'b001;
        d1[1] = 8'h56; d2[1] = 8'h78; sel[1] = 3'b011;
        v = 2'b11; rr = 2'b11; v4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (m_acc >= 0) begin ids.push_back(m_acc); cycs.push_back(i); end
        end
        v = 2'b00; v4 = 1'b0;
        chk("rr_count", ids.size() >= 4, 1);
        chk("rr4_count", q4_id.size() >= 4, 1);
        for (int i = 0; i < 4 && i < ids.size(); i++) begin
            chk("rr_order", ids[i], i % 2);
            if (i > 0) chk("rr_gap", cycs[i] - cycs[i-1], 3);
        end
        for (int i = 0; i < 4 && i < q4_id.size(); i++) begin
            chk("rr4_order", q4_id[i], i % 2);
            if (i > 0) chk("rr4_gap", q4_cyc[i] - q4_cyc[i-1], 6);
        end
        drain();

        run_req(0, 8'hAA, 8'h55, 3'b101, lat);
        chk("ill_lat", lat, 1);
        chk("ill_err", rsp_err, 1);
        chk("ill_res", rsp_res, 8'h00);
        chk("ill_alu_sel", alu_sel, m_as);

        rr = 2'b10;
        d1[0] = 8'h10; d2[0] = 8'h20; sel[0] = 3'b001; v[0] = 1'b1;
        for (int i = 0; i < 20 && m_acc != 0; i++) cyc();
        chk("stall_acc0", m_acc, 0);
        v[0] = 1'b0;
        d1[1] = 8'h3C; d2[1] = 8'h0F; sel[1] = 3'b010; v[1] = 1'b1;
        repeat (6) cyc();
        chk("stall_rspv0", rv0, 1);
        chk("stall_res", rsp_res, 8'h30);
        rr = 2'b11; hd = -100; ac = -1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (m_done) hd = i;
            if (m_acc == 1) begin ac = i; break; end
        end
        chk("stall_gap", ac - hd, 1);
        v[1] = 1'b0;
        drain();

        d1[0] = 8'h40; d2[0] = 8'h02; sel[0] = 3'b011; v[0] = 1'b1;
        for (int i = 0; i < 20 && m_acc != 0; i++) cyc();
        chk("mid_acc0", m_acc, 0);
        v = 2'b11;
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            cyc();
            if (m_acc >= 0) first = m_acc;
        end
        chk("midrst_first", first, 0);
        v = 2'b00;
        drain();

        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0) v[n] = ~v[n];
                d1[n] = 8'($urandom);
                d2[n] = 8'($urandom);
                sel[n] = ($urandom_range(0, 4) == 0) ? {1'b1, 2'($urandom)} : {1'b0, 2'($urandom)};
            end
            rr = 2'($urandom);
            cyc();
        end
        v = 2'b00; rr = 2'b11;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit ALU (FORWARD/ADD/AND/OR, 3-bit SELECT, ZERO flag). Two requesters each present an operation: DATA1, DATA2 and SELECT. The block grants one requester at a time and registers its operands onto the ALU inputs. It waits a programmable settle time, captures RESULT/ZERO, and returns them to the granted requester over a valid/ready response handshake.

## Interface
Parameters:
- SETTLE, default 1: cycles ALU inputs are held before RESULT/ZERO are captured; legal range 1–4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0_VALID, REQ1_VALID  in  1  request present.
- REQ0_READY, REQ1_READY  out  1  request accepted this cycle (combinational).
- REQ0_DATA1, REQ1_DATA1  in  8  operand 1.
- REQ0_DATA2, REQ1_DATA2  in  8  operand 2.
- REQ0_SELECT, REQ1_SELECT  in  3  ALU function: 000 FWD, 001 ADD, 010 AND, 011 OR.
- ALU_DATA1, ALU_DATA2  out  8  registered ALU operands.
- ALU_SELECT  out  3  registered ALU function.
- ALU_RESULT  in  8  ALU result.
- ALU_ZERO  in  1  ALU zero flag.
- RSP0_VALID, RSP1_VALID  out  1  response valid for that requester.
- RSP0_READY, RSP1_READY  in  1  requester takes response.
- RSP_RESULT  out  8  captured result, shared by both responses.
- RSP_ZERO  out  1  captured zero flag.
- RSP_ERR  out  1  request had illegal SELECT (bit 2 set).

## Operation
- States: IDLE, EXEC, RESP. Registered LAST (last granted id), OWNER (current id), settle counter CNT (2 bits).
- IDLE grant rules:
  - Only one REQn_VALID high: grant n.
  - Both high: grant the id not equal to LAST.
  - REQn_READY = (state==IDLE) & grant==n & REQn_VALID & RESET high. At most one READY is high at a time.
- Accept (READY & VALID):
  - OWNER<=n, LAST<=n.
  - If SELECT[2]==0: load ALU_DATA1/ALU_DATA2/ALU_SELECT from requester n, CNT<=SETTLE-1, go to EXEC.
  - If SELECT[2]==1: ALU_* registers unchanged; RSP_RESULT<=0, RSP_ZERO<=0, RSP_ERR<=1; go to RESP.
- EXEC: if CNT!=0 then CNT<=CNT-1; else capture RSP_RESULT<=ALU_RESULT, RSP_ZERO<=ALU_ZERO, RSP_ERR<=0, and go to RESP.
- RESP:
  - RSPn_VALID = (state==RESP) & OWNER==n.
  - On RSPn_READY high: go to IDLE.
  - RSP_* outputs are stable while RSPn_VALID is high.
- ALU_* registers hold their last values outside accept cycles; no toggling in IDLE or RESP.
- Width rules: no arithmetic in this block. Results are passed through unmodified, including the 8-bit ADD wrap (0xFF+0x01 → 0x00, ZERO=1).
- Reset (asynchronous, RESET low) forces:
  - State IDLE, LAST=1 (so requester 0 wins the first tie), OWNER=0, CNT=0.
  - ALU_DATA1=0, ALU_DATA2=0, ALU_SELECT=000.
  - RSP_RESULT=0, RSP_ZERO=0, RSP_ERR=0.
  - Both REQn_READY=0, both RSPn_VALID=0.
  - A request accepted before a mid-operation reset is dropped; no response is issued.

## Timing
- Accept in cycle k (IDLE handshake); ALU_* show the new operands from cycle k+1.
- Capture at the end of cycle k+SETTLE; RSPn_VALID is high from cycle k+SETTLE+1.
- Illegal-SELECT response: RSPn_VALID is high from cycle k+1.
- Response handshake in cycle m → IDLE in cycle m+1, when the next grant is possible.
- Minimum spacing between accepts: SETTLE+2 cycles (SETTLE=1 gives 3).
- A requester may hold VALID high across its own response; it re-arbitrates fairly against the other requester.
- A requester's VALID falling before READY withdraws that request.

## Test plan
- SETTLE=1; REQ0 DATA1=0x05, DATA2=0x03, SELECT=001, accepted cycle k → RSP0_VALID at k+2, RSP_RESULT=0x08, ZERO=0, ERR=0; RSP1_VALID stays 0.
- REQ1 AND 0xF0,0x0F, then ADD 0xFF,0x01 → RSP_RESULT=0x00, ZERO=1 both times; ALU_SELECT=010 then 001 during the respective EXEC.
- Both VALID held high, RSP_READY tied high → grant order 0,1,0,1 from reset; one accept every 3 cycles (SETTLE=1), every 6 cycles with SETTLE=4.
- REQ0 SELECT=101 → RSP0_VALID the cycle after accept, RSP_ERR=1, RSP_RESULT=0x00; ALU_* unchanged from their previous values.
- RSP0_READY held low for 5 cycles → RSP0_VALID/RSP_RESULT/RSP_ZERO stable; REQ1_READY stays 0 despite REQ1_VALID=1; REQ1 accepted the cycle after the RSP0 handshake.
- RESET pulsed low during EXEC → all outputs take their reset values immediately; no response for the dropped request; with both requests then pending, REQ0 wins first.
